// File: rtl/xg_dmem_port_if.sv
// xg_dmem_port_if
//   Bundle between the core's MEM stage (master) and the data-memory port
//   (slave).
//
//   Handshake: the master raises req_valid with a request and keeps every
//   req_* field stable while stall=1. The slave accepts the request in the
//   cycle it sees req_valid=1 while idle. It completes the request by
//   pulsing rsp_valid for one cycle, and stall is 0 in that cycle. A request
//   that is presented during the completion cycle is accepted one cycle
//   later.
//
//   Signals
//     req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata
//       master -> slave
//     stall, rsp_valid, rsp_rdata, rsp_err
//       slave -> master
interface xg_dmem_port_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              stall;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  stall, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output stall, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/xg_dmem_port.sv
// xg_dmem_port
//   Data-memory port for the pipelined xg-riscv core. It provides on-chip
//   word storage with a programmable access latency. The port stalls the
//   pipeline while an access is in flight. It also steers byte, half and
//   word lanes, extends loads, and flags misaligned accesses.
//
//   Ports
//     clk        core clock
//     reset      asynchronous, active-high reset
//     bus        xg_dmem_port_if slave: request in, stall/response out
//     dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module xg_dmem_port #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    xg_dmem_port_if.slave  bus,
    output logic [1:0]     dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [3:0]       cnt;
    logic             r_write;
    logic             r_unsigned;
    logic [1:0]       r_size;
    logic [IDX_W+1:0] r_addr;     // only the bits that select a word and lane
    logic [XLEN-1:0]  r_wdata;
    logic [XLEN-1:0]  rdata_q;
    logic             err_q;

    logic [XLEN-1:0]  mem [DEPTH];

    logic             accept;
    logic             access;
    logic             misaligned;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [XLEN-1:0]  wlane;
    logic [XLEN-1:0]  rword;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_ext;

    assign accept     = (state == IDLE) && bus.req_valid;
    assign access     = (state == BUSY) && (cnt == 4'd0);
    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign idx        = r_addr[IDX_W+1:2];
    assign dbg_state  = state;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = misaligned ? DONE : BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE:    bus.stall     = bus.req_valid;
            BUSY:    bus.stall     = 1'b1;
            DONE:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Request capture, wait counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 4'd0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                r_write    <= bus.req_write;
                r_unsigned <= bus.req_unsigned;
                r_size     <= bus.req_size;
                r_addr     <= bus.req_addr[IDX_W+1:0];
                r_wdata    <= bus.req_wdata;
                cnt        <= 4'(WAIT_CYCLES);
                // A misaligned access skips the array and completes next cycle.
                if (misaligned) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err_q   <= 1'b0;
                rdata_q <= r_write ? '0 : load_ext;
            end
        end
    end

    // Store lane steering: replicate the data so that every lane already
    // holds the right bytes, and let the byte enables choose the lanes.
    always_comb begin
        be    = 4'b0000;
        wlane = r_wdata;
        case (r_size)
            2'b00: begin
                be    = 4'b0001 << r_addr[1:0];
                wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                be    = r_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = r_wdata;
            end
        endcase
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    // Load lane selection and extension
    assign rword   = mem[idx];
    assign shifted = rword >> {r_addr[1:0], 3'b000};

    always_comb begin
        load_ext = shifted;
        case (r_size)
            2'b00:   load_ext = r_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                           : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = r_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                           : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default: load_ext = rword;
        endcase
    end
endmodule
